// File: rtl/sma_chan_sched_if.sv
// sma_chan_sched_if: per-channel sample inputs and
// the shared registered result port.
interface sma_chan_sched_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  localparam int CW =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] in_x;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_y;
  logic [CW-1:0]             out_ch;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_y, out_ch
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_y, out_ch
  );
endinterface

// File: rtl/sma_chan_sched.sv
// sma_chan_sched: round-robin shared 4-tap moving
// average over CHANNELS sample streams.
module sma_chan_sched #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input logic clk,
  input logic rst,
  input logic flush,
  sma_chan_sched_if.slave bus
);
  localparam int CW =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = WIDTH + 2;

  logic signed [WIDTH-1:0] h1 [CHANNELS];
  logic signed [WIDTH-1:0] h2 [CHANNELS];
  logic signed [WIDTH-1:0] h3 [CHANNELS];
  logic [CW-1:0]           ptr;

  logic                    ov;
  logic [WIDTH-1:0]        oy;
  logic [CW-1:0]           och;

  logic                    slot_free;
  logic                    gnt_vld;
  logic                    xfer;
  logic [CW-1:0]           gnt;
  logic [CHANNELS-1:0]     rot;
  int                      off;

  logic signed [WIDTH-1:0] x;
  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    adj;
  logic [WIDTH-1:0]        avg;

  assign slot_free = !ov || bus.out_ready;

  // requests rotated so bit 0 is the channel after ptr
  assign rot = CHANNELS'(
    {bus.in_valid, bus.in_valid} >> (int'(ptr) + 1));

  // lowest set bit of the rotated view wins
  always_comb begin
    gnt_vld = 1'b0;
    off     = 0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        gnt_vld = 1'b1;
        off     = j;
      end
    end
  end

  assign gnt  = CW'((int'(ptr) + 1 + off) % CHANNELS);
  assign xfer = rst && slot_free && !flush && gnt_vld;

  // one-hot accept for the granted channel only
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.in_ready[i] = xfer && (gnt == CW'(i));
    end
  end

  assign x   = bus.in_x[int'(gnt)*WIDTH +: WIDTH];
  assign sum = SW'(x) + SW'(h1[gnt])
             + SW'(h2[gnt]) + SW'(h3[gnt]);
  // bias negatives by 3 so the shift rounds toward zero
  assign adj = sum + {{(SW-2){1'b0}},
                      sum[SW-1], sum[SW-1]};
  assign avg = WIDTH'(adj >>> 2);

  // histories, arbitration pointer and result register
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        h1[i] <= '0;
        h2[i] <= '0;
        h3[i] <= '0;
      end
      ptr <= CW'(CHANNELS - 1);
      ov  <= 1'b0;
      oy  <= '0;
      och <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < CHANNELS; i++) begin
          h1[i] <= '0;
          h2[i] <= '0;
          h3[i] <= '0;
        end
      end else if (xfer) begin
        h3[gnt] <= h2[gnt];
        h2[gnt] <= h1[gnt];
        h1[gnt] <= x;
      end
      if (xfer) begin
        ov  <= 1'b1;
        oy  <= avg;
        och <= gnt;
        ptr <= gnt;
      end else if (ov && bus.out_ready) begin
        ov  <= 1'b0;
      end
    end
  end

  assign bus.out_valid = ov;
  assign bus.out_y     = oy;
  assign bus.out_ch    = och;
endmodule

// File: tb/tb_sma_chan_sched.sv
// tb_sma_chan_sched: scoreboard bench for the
// shared moving-average scheduler.
module tb_sma_chan_sched;
  localparam int CH = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  sma_chan_sched_if #(
    .CHANNELS(CH), .WIDTH(W)
  ) bus ();

  sma_chan_sched #(
    .CHANNELS(CH), .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus)
  );

  typedef struct {
    int ch;
    int y;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   xs  [CH];
  int   mh1 [CH];
  int   mh2 [CH];
  int   mh3 [CH];
  int   mptr;
  bit   mvalid;
  int   last_y;
  int   last_ch;
  bit   post_rst;
  int   post_rst_y;

  task automatic chk(
    input string             tag,
    input logic signed [31:0] got,
    input logic signed [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < CH; i++)
      bus.in_x[i*W +: W] = W'(xs[i]);
  endtask

  task automatic clr_hist();
    for (int i = 0; i < CH; i++) begin
      mh1[i] = 0;
      mh2[i] = 0;
      mh3[i] = 0;
    end
  endtask

  task automatic cyc();
    int           g;
    bit           gv;
    logic [CH-1:0] er;
    exp_t         e;
    drive();
    #4;
    er = '0;
    gv = 1'b0;
    g  = 0;
    if (rst && (!mvalid || bus.out_ready) && !flush) begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (mptr + k) % CH;
        if (!gv && bus.in_valid[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
    if (gv) er[g] = 1'b1;
    chk("in_ready", bus.in_ready, er);
    chk("out_valid", bus.out_valid, mvalid);
    if (mvalid) begin
      if (q.size() == 0) begin
        chk("sb_pop", q.size(), 1);
      end else if (bus.out_ready) begin
        e = q.pop_front();
        chk("out_y", $signed(bus.out_y), e.y);
        chk("out_ch", bus.out_ch, e.ch);
        last_y  = $signed(bus.out_y);
        last_ch = int'(bus.out_ch);
        if (post_rst) begin
          chk("rst_first_ch", bus.out_ch, 0);
          chk("rst_first_y", $signed(bus.out_y),
              post_rst_y);
          post_rst = 1'b0;
        end
      end else begin
        e = q[0];
        chk("hold_y", $signed(bus.out_y), e.y);
        chk("hold_ch", bus.out_ch, e.ch);
      end
    end
    if (!rst) begin
      q.delete();
      clr_hist();
      mptr   = CH - 1;
      mvalid = 1'b0;
    end else begin
      if (flush) begin
        clr_hist();
      end else if (gv) begin
        int s;
        s    = xs[g] + mh1[g] + mh2[g] + mh3[g];
        e.ch = g;
        e.y  = s / 4;
        q.push_back(e);
        mh3[g] = mh2[g];
        mh2[g] = mh1[g];
        mh1[g] = xs[g];
        mptr   = g;
        mvalid = 1'b1;
      end
      if (!gv && mvalid && bus.out_ready)
        mvalid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = '0;
    repeat (n) cyc();
  endtask

  task automatic run1(input int ch, input int v,
                      input int n);
    bus.in_valid     = '0;
    bus.in_valid[ch] = 1'b1;
    xs[ch]           = v;
    repeat (n) cyc();
  endtask

  initial begin
    int p1[4];
    p1 = '{4, 8, 12, 16};
    rst           = 1'b0;
    flush         = 1'b0;
    post_rst      = 1'b0;
    post_rst_y    = 0;
    last_y        = 0;
    last_ch       = 0;
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    xs            = '{default: 0};
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    mvalid = 1'b0;
    mptr   = CH - 1;
    clr_hist();
    chk("rst_ovld", bus.out_valid, 0);
    chk("rst_y", $signed(bus.out_y), 0);
    chk("rst_ch", bus.out_ch, 0);
    chk("rst_rdy", bus.in_ready, 0);
    rst          = 1'b1;
    bus.in_valid = '0;

    bus.in_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      xs[0] = p1[i];
      cyc();
    end
    idle(2);
    chk("p1_last_y", last_y, 10);
    chk("p1_last_ch", last_ch, 0);

    run1(1, -1, 3);
    run1(1, -2, 1);
    idle(2);
    chk("trunc_y", last_y, -1);
    run1(1, -32768, 4);
    idle(2);
    chk("min_y", last_y, -32768);
    run1(1, 32767, 4);
    idle(2);
    chk("max_y", last_y, 32767);

    xs           = '{100, 200, -300, 400};
    bus.in_valid = '1;
    repeat (16) cyc();
    idle(2);
    chk("rr_last_ch", last_ch, 1);
    chk("rr_last_y", last_y, 200);

    xs[2]         = 40;
    xs[3]         = 80;
    bus.in_valid  = 4'b1100;
    bus.out_ready = 1'b0;
    repeat (6) cyc();
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    idle(2);

    xs[0]         = 50;
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b0;
    cyc();
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    xs[0]         = 8;
    cyc();
    chk("flush_pend_y", last_y, 87);
    flush = 1'b0;
    cyc();
    idle(2);
    chk("flush_y", last_y, 2);

    xs           = '{100, 200, -300, 400};
    bus.in_valid = '1;
    repeat (5) cyc();
    rst = 1'b0;
    cyc();
    rst        = 1'b1;
    post_rst   = 1'b1;
    post_rst_y = 25;
    chk("rst_mid_ovld", bus.out_valid, 0);
    repeat (8) cyc();
    idle(2);

    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/sma_chan_sched.md
# sma_chan_sched

Time-multiplexed 4-tap simple-moving-average engine shared by `CHANNELS` independent sample streams. A round-robin arbiter grants one requesting channel per cycle. The granted sample is combined with that channel's private three-sample history to produce `(x + x_prev1 + x_prev2 + x_prev3) / 4`. The result is emitted through a registered valid/ready output port tagged with the channel index. The block sits between per-channel sample sources and a single downstream consumer, so one adder tree serves all channels.

## Interface
- `CHANNELS`, 4 — number of input streams; legal range 2..16.
- `WIDTH`, 16 — signed sample width; legal range ≥ 2.
- `CW` (localparam) = max(1, clog2(`CHANNELS`)) — width of the channel index.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — reset is synchronous and active-low: `rst == 0` at a rising edge of `clk` resets the block.
- `flush` in 1 — synchronous clear of all channel histories.
- `in_valid` in `CHANNELS` — per-channel sample valid.
- `in_ready` out `CHANNELS` — per-channel accept; combinational, at most one bit set.
- `in_x` in `CHANNELS`*`WIDTH` — packed signed samples; channel i is at `[i*WIDTH +: WIDTH]`.
- `out_valid` out 1 — result valid, registered.
- `out_ready` in 1 — downstream accept.
- `out_y` out `WIDTH` — signed average, registered.
- `out_ch` out `CW` — channel index of `out_y`, registered.

## Operation
- **State**
  - Per channel: `h1`, `h2`, `h3`, each a signed `WIDTH`-bit register holding the previous three accepted samples, newest first.
  - `ptr`: index of the last granted channel, `CW` bits.
  - Output register: `out_valid`, `out_y`, `out_ch`.
- **Slot availability:** `slot_free = !out_valid || out_ready`.
- **Arbitration**
  - When `slot_free && !flush`, grant the first channel with `in_valid` set, scanning `ptr+1, ptr+2, …` modulo `CHANNELS`.
  - `in_ready[g] = 1` for the granted channel `g` only. All other bits, and all bits when there is no grant, are 0.
  - `in_ready` may depend on `in_valid`. Senders must not make `in_valid` depend on `in_ready`.
- **Transfer:** channel i transfers when `in_valid[i] && in_ready[i]`. On a transfer:
  - `sum = x + h1[g] + h2[g] + h3[g]`, computed at `WIDTH+2` bits with sign extension; no overflow is possible.
  - `avg = sum / 4` as signed division, truncating toward zero (not an arithmetic shift). `avg` always fits in `WIDTH` bits; the low `WIDTH` bits are taken.
  - Next edge: `out_y <= avg`, `out_ch <= g`, `out_valid <= 1`, `ptr <= g`.
  - Next edge: `h3[g] <= h2[g]`, `h2[g] <= h1[g]`, `h1[g] <= x`. Histories of other channels are unchanged.
- **No transfer:** if `out_valid && out_ready`, then `out_valid <= 0`. Otherwise `out_valid` holds. `out_y` and `out_ch` hold in both cases.
- **Flush**
  - All histories clear to 0 at the next edge and all `in_ready` are 0 that cycle.
  - `ptr` and the output register are unaffected; a pending result is still delivered.
- **Reset** (`rst == 0` at an edge), overriding `flush` and any transfer:
  - All histories → 0, `ptr` → `CHANNELS-1`, so channel 0 has first priority.
  - `out_valid` → 0, `out_y` → 0, `out_ch` → 0.
  - While `rst == 0`, all `in_ready` are forced to 0.

## Timing
- Latency: transfer in cycle n → `out_valid` with the result in cycle n+1.
- Throughput: one result per cycle when `out_ready` is held at 1. Each channel receives at least one grant every `CHANNELS` cycles while it requests.
- Backpressure: while `out_valid && !out_ready`, `out_y` and `out_ch` are stable and no grant is issued.
- A result consumed in cycle n can be replaced by a new transfer in the same cycle n, so the output stays bubble-free.
- Reset mid-operation: an in-flight result is discarded and the first post-reset result for every channel uses zero history.
- Simultaneous `flush` and a pending `out_valid`: the pending result is kept, histories are cleared, and no new sample is accepted that cycle.

## Test plan
- **Single channel, no backpressure.**
  - Stimulus: reset, then ch0 sends 4, 8, 12, 16 on consecutive cycles, `out_ready = 1`.
  - Required: `out_y` = 1, 3, 6, 10 in cycles 1..4 after the first transfer; `out_ch = 0`.
- **Truncation and extremes.**
  - Stimulus: ch1 sends −1, −1, −1, −2.
  - Required: last `out_y = −1`, because −5/4 truncates toward zero, not −2.
  - Stimulus: four samples of −32768, then four of 32767 (`WIDTH = 16`).
  - Required: −32768 and 32767 respectively on the fourth sample of each run.
- **Round-robin fairness.**
  - Stimulus: all 4 channels hold `in_valid = 1` continuously with distinct constant samples.
  - Required: `out_ch` sequence 0, 1, 2, 3, 0, 1, …; no channel is starved; each channel's average converges after its 4th grant.
- **Backpressure.**
  - Stimulus: `out_ready = 0` for 5 cycles while ch2 and ch3 request.
  - Required: `out_y` and `out_ch` are frozen; `in_ready` is all 0 after the first transfer; no history changes.
  - Stimulus: release `out_ready`.
  - Required: the next results resume with no sample lost or duplicated.
- **Flush with pending output.**
  - Stimulus: ch0 history is nonzero and `out_valid = 1`; assert `flush` for 1 cycle.
  - Required: the pending result is delivered unchanged.
  - Stimulus: next ch0 sample 8.
  - Required: `out_y = 2`.
- **Reset mid-stream.**
  - Stimulus: pull `rst` low for 1 cycle during continuous traffic.
  - Required: `out_valid = 0` the next cycle; the following first grant goes to channel 0; every channel's first post-reset result equals x/4.
